demux4_buffered: RTL and testbench

DEMUX4_BUFFERED -- requirements
Module: demux4_buffered

---
 rtl/demux4_buffered.sv | 103 ++++++++++
 tb/tb_demux4_buffered.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/demux4_buffered.sv
// Routes one input stream to four independently buffered output channels.
// Each channel has its own FIFO, head-of-queue output and acceptance counter.
module demux4_buffered #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [15:0]      count0,
  output logic [15:0]      count1,
  output logic [15:0]      count2,
  output logic [15:0]      count3
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] OCC_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r    [4][DEPTH];
  logic [PTR_W-1:0] wr_ptr_r [4];
  logic [PTR_W-1:0] rd_ptr_r [4];
  logic [PTR_W:0]   occ_r    [4];
  logic [15:0]      count_r  [4];
  logic [WIDTH-1:0] head_s   [4];
  logic [3:0]       full_s;
  logic [3:0]       empty_s;
  logic [3:0]       sel_dec_s;
  logic [3:0]       push_s;
  logic [3:0]       pop_s;

  // Per-channel status flags and head-of-queue data (zero when empty).
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      full_s[k]  = (occ_r[k] == OCC_FULL);
      empty_s[k] = (occ_r[k] == '0);
      head_s[k]  = empty_s[k] ? '0 : mem_r[k][rd_ptr_r[k]];
    end
  end

  // in_ready depends only on select and registered occupancy, never on out_ready.
  always_comb begin
    sel_dec_s = 4'b0001 << select;
    in_ready  = ~full_s[select];
    push_s    = sel_dec_s & {4{in_valid & in_ready}};
    pop_s     = ~empty_s & out_ready;
  end

  // Pointer, occupancy and counter state for all four channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        wr_ptr_r[k] <= '0;
        rd_ptr_r[k] <= '0;
        occ_r[k]    <= '0;
        count_r[k]  <= 16'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push_s[k]) begin
          wr_ptr_r[k] <= wr_ptr_r[k] + PTR_W'(1);
          count_r[k]  <= count_r[k] + 16'd1;
        end
        if (pop_s[k]) begin
          rd_ptr_r[k] <= rd_ptr_r[k] + PTR_W'(1);
        end
        case ({push_s[k], pop_s[k]})
          2'b10:   occ_r[k] <= occ_r[k] + (PTR_W + 1)'(1);
          2'b01:   occ_r[k] <= occ_r[k] - (PTR_W + 1)'(1);
          default: occ_r[k] <= occ_r[k];
        endcase
      end
    end
  end

  // Storage array; contents need no reset because empty channels output zero.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (push_s[k]) begin
        mem_r[k][wr_ptr_r[k]] <= in_data;
      end
    end
  end

  assign out0      = head_s[0];
  assign out1      = head_s[1];
  assign out2      = head_s[2];
  assign out3      = head_s[3];
  assign out_valid = ~empty_s;
  assign count0    = count_r[0];
  assign count1    = count_r[1];
  assign count2    = count_r[2];
  assign count3    = count_r[3];

endmodule

// File: tb/tb_demux4_buffered.sv
// Directed self-checking bench for demux4_buffered (WIDTH=32, DEPTH=2).
module tb_demux4_buffered;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [1:0]  select;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out0, out1, out2, out3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] count0, count1, count2, count3;

  int checks = 0;
  int failures = 0;

  demux4_buffered #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .select(select),
    .in_valid(in_valid), .in_ready(in_ready),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_valid(out_valid), .out_ready(out_ready),
    .count0(count0), .count1(count1), .count2(count2), .count3(count3)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    rst_n     = 1'b0;
    #3;
    rst_n     = 1'b1;
  endtask

  task automatic push(input logic [1:0] sel, input logic [31:0] d);
    in_valid = 1'b1;
    select   = sel;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    select    = 2'd0;
    out_ready = 4'b0000;
    #2;
    // Reset state
    check_eq("rst_out_valid", {28'd0, out_valid}, 32'h0);
    check_eq("rst_out0", out0, 32'h0);
    check_eq("rst_out3", out3, 32'h0);
    check_eq("rst_count0", {16'd0, count0}, 32'h0);
    for (int s = 0; s < 4; s++) begin
      select = 2'(s);
      #1;
      check_eq($sformatf("rst_in_ready_sel%0d", s), {31'd0, in_ready}, 32'h1);
    end
    #4;
    rst_n = 1'b1;

    // Single routing
    push(2'd0, 32'h11);
    push(2'd1, 32'h22);
    push(2'd2, 32'h33);
    push(2'd3, 32'h44);
    check_eq("route_valid", {28'd0, out_valid}, 32'hF);
    check_eq("route_out0", out0, 32'h11);
    check_eq("route_out1", out1, 32'h22);
    check_eq("route_out2", out2, 32'h33);
    check_eq("route_out3", out3, 32'h44);
    check_eq("route_cnt0", {16'd0, count0}, 32'h1);
    check_eq("route_cnt1", {16'd0, count1}, 32'h1);
    check_eq("route_cnt2", {16'd0, count2}, 32'h1);
    check_eq("route_cnt3", {16'd0, count3}, 32'h1);
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;
    check_eq("drain_valid", {28'd0, out_valid}, 32'h0);
    check_eq("drain_out1", out1, 32'h0);

    // Full / backpressure on channel 2
    do_reset();
    push(2'd2, 32'hA0);
    push(2'd2, 32'hA1);
    check_eq("bp_head", out2, 32'hA0);
    in_valid = 1'b1;
    in_data  = 32'hA2;
    select   = 2'd0;
    #1;
    check_eq("bp_ready_sel0", {31'd0, in_ready}, 32'h1);
    select = 2'd2;
    #1;
    check_eq("bp_ready_sel2", {31'd0, in_ready}, 32'h0);
    repeat (3) step();
    check_eq("bp_cnt_hold", {16'd0, count2}, 32'h2);
    out_ready[2] = 1'b1;
    #1;
    check_eq("bp_no_ready_path", {31'd0, in_ready}, 32'h0);
    step();
    out_ready[2] = 1'b0;
    check_eq("bp_after_pop_head", out2, 32'hA1);
    check_eq("bp_after_pop_ready", {31'd0, in_ready}, 32'h1);
    check_eq("bp_after_pop_cnt", {16'd0, count2}, 32'h2);
    step();
    in_valid = 1'b0;
    check_eq("bp_accept_cnt", {16'd0, count2}, 32'h3);
    check_eq("bp_accept_head", out2, 32'hA1);
    out_ready[2] = 1'b1;
    step();
    check_eq("bp_second", out2, 32'hA2);
    step();
    out_ready[2] = 1'b0;
    check_eq("bp_empty", {31'd0, out_valid[2]}, 32'h0);

    // Streaming on channel 1
    do_reset();
    out_ready[1] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      select   = 2'd1;
      in_data  = 32'(i);
      #1;
      check_eq($sformatf("stream_ready_%0d", i), {31'd0, in_ready}, 32'h1);
      step();
      check_eq($sformatf("stream_out_%0d", i), out1, 32'(i));
      check_eq($sformatf("stream_valid_%0d", i), {31'd0, out_valid[1]}, 32'h1);
    end
    in_valid = 1'b0;
    step();
    out_ready[1] = 1'b0;
    check_eq("stream_empty", {31'd0, out_valid[1]}, 32'h0);
    check_eq("stream_cnt", {16'd0, count1}, 32'h8);

    // Pointer wrap on channel 3
    do_reset();
    push(2'd3, 32'h30);
    out_ready[3] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      select   = 2'd3;
      in_data  = 32'h30 + 32'(i);
      #1;
      check_eq($sformatf("wrap_pre_%0d", i), out3, 32'h30 + 32'(i - 1));
      step();
      check_eq($sformatf("wrap_post_%0d", i), out3, 32'h30 + 32'(i));
    end
    in_valid = 1'b0;
    step();
    out_ready[3] = 1'b0;
    check_eq("wrap_empty", {31'd0, out_valid[3]}, 32'h0);
    check_eq("wrap_cnt", {16'd0, count3}, 32'h6);

    // Counter wrap on channel 0
    do_reset();
    out_ready[0] = 1'b1;
    in_valid     = 1'b1;
    select       = 2'd0;
    in_data      = 32'hC0;
    repeat (65535) step();
    check_eq("cnt_ffff", {16'd0, count0}, 32'hFFFF);
    step();
    check_eq("cnt_wrap", {16'd0, count0}, 32'h0);
    in_valid     = 1'b0;
    step();
    out_ready[0] = 1'b0;

    // Asynchronous reset mid-operation
    do_reset();
    push(2'd0, 32'h61);
    push(2'd1, 32'h62);
    check_eq("ar_pre_valid", {28'd0, out_valid}, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_valid", {28'd0, out_valid}, 32'h0);
    check_eq("ar_cnt0", {16'd0, count0}, 32'h0);
    check_eq("ar_cnt1", {16'd0, count1}, 32'h0);
    check_eq("ar_out1", out1, 32'h0);
    in_valid = 1'b1;
    select   = 2'd1;
    in_data  = 32'h77;
    step();
    check_eq("ar_no_push", {28'd0, out_valid}, 32'h0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    push(2'd1, 32'h55);
    check_eq("ar_out1_new", out1, 32'h55);
    check_eq("ar_valid_new", {28'd0, out_valid}, 32'h2);
    check_eq("ar_cnt1_new", {16'd0, count1}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
